random_delay_timer: RTL and testbench

- Consumes the 7-bit pseudo-random value from the team's LFSR and converts it into a randomised wait for the lights-out / reaction-time sequence.
- On `trigger`, latches the LFSR value as a tick count and counts it down at a prescaled tick rate.
- Pulses `time_out` when the count expires.
- Drives the LFSR enable so the generator free-runs while idle and is frozen during a countdown.

---
 rtl/random_delay_timer.sv | 93 +++++++++
 tb/tb_random_delay_timer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/random_delay_timer.sv
// Randomised delay timer: latches an LFSR value on trigger and counts it down
// in prescaled ticks, pulsing time_out at expiry. The LFSR free-runs only while idle.
module random_delay_timer #(
   parameter int WIDTH    = 7,
   parameter int PRESCALE = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trigger,
   input  logic             abort,
   input  logic [WIDTH-1:0] k,
   output logic             lfsr_en,
   output logic             busy,
   output logic             time_out,
   output logic [WIDTH-1:0] count_out
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    psc;
   logic [WIDTH-1:0] cnt;
   logic             start;
   logic             tick;

   assign start = trigger & ~abort;
   assign tick  = (psc == PSC_LAST);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = COUNT;
         COUNT: begin
            if (abort)                        state_nxt = IDLE;
            else if (tick && cnt == WIDTH'(1)) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Tick counter and prescaler; a zero LFSR value is promoted to one tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         psc <= '0;
      end else begin
         case (state)
            IDLE: begin
               psc <= '0;
               if (start) cnt <= (k == '0) ? WIDTH'(1) : k;
            end
            COUNT: begin
               if (abort) begin
                  cnt <= '0;
                  psc <= '0;
               end else if (tick) begin
                  cnt <= cnt - WIDTH'(1);
                  psc <= '0;
               end else begin
                  psc <= psc + PW'(1);
               end
            end
            default: begin
               cnt <= '0;
               psc <= '0;
            end
         endcase
      end
   end

   always_comb begin
      lfsr_en   = (state == IDLE);
      busy      = (state == COUNT) || (state == DONE);
      time_out  = (state == DONE);
      count_out = cnt;
   end

endmodule

// File: tb/tb_random_delay_timer.sv
// Self-checking bench for random_delay_timer: two instances (PRESCALE=4 and 1)
// compared against expectations computed from tick arithmetic.
module tb_random_delay_timer;

   localparam int W = 7;

   logic         clk;
   logic         rst;
   logic         trig4, abort4, trig1, abort1;
   logic [W-1:0] k4, k1;
   logic         en4, busy4, to4, en1, busy1, to1;
   logic [W-1:0] cnt4, cnt1;

   int n_checks = 0;
   int n_fail   = 0;

   random_delay_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .trigger(trig4), .abort(abort4), .k(k4),
      .lfsr_en(en4), .busy(busy4), .time_out(to4), .count_out(cnt4)
   );

   random_delay_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .trigger(trig1), .abort(abort1), .k(k1),
      .lfsr_en(en1), .busy(busy1), .time_out(to1), .count_out(cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at the negedge just after E0. Expected outputs j edges after E0:
   // count = N - j/4 while j < 4N, DONE with time_out at j = 4N.
   // abort_j >= 0 pulses abort at that sample and returns after the abort edge.
   task automatic follow4(input string name, input int n, input logic [W-1:0] next_k,
                          input bit scramble, input int abort_j);
      logic [W+2:0] got, exp;
      for (int j = 0; j <= n * 4; j++) begin
         exp = {1'b0, 1'b1, (j == n * 4), (j < n * 4) ? W'(n - j / 4) : W'(0)};
         got = {en4, busy4, to4, cnt4};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s n=%0d j=%0d {en,busy,to,cnt} got %b required %b", name, n, j, got, exp);
         end
         if (j == abort_j) begin
            abort4 = 1'b1;
            @(negedge clk);
            abort4 = 1'b0;
            return;
         end
         if (scramble && j < n * 4) k4 = W'($urandom);
         if (j == n * 4) k4 = next_k;
         @(negedge clk);
      end
   endtask

   task automatic expect_idle4(input string name, input int cycles);
      logic [W+2:0] got;
      for (int i = 0; i < cycles; i++) begin
         got = {en4, busy4, to4, cnt4};
         n_checks++;
         if (got !== {1'b1, 1'b0, 1'b0, W'(0)}) begin
            n_fail++;
            $display("FAIL %s cycle=%0d {en,busy,to,cnt} got %b required %b", name, i, got,
                     {1'b1, 1'b0, 1'b0, W'(0)});
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse4(input logic [W-1:0] kv);
      k4   = kv;
      trig4 = 1'b1;
      @(negedge clk);
      trig4 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      trig4 = 1'b0; abort4 = 1'b0; k4 = '0;
      trig1 = 1'b0; abort1 = 1'b0; k1 = '0;
      #1;
      n_checks++;
      if ({en4, busy4, to4, cnt4, en1, busy1, to1, cnt1} !==
          {1'b1, 1'b0, 1'b0, W'(0), 1'b1, 1'b0, 1'b0, W'(0)}) begin
         n_fail++;
         $display("FAIL reset_state got %b/%b required 1,0,0,0 for both", {en4, busy4, to4, cnt4},
                  {en1, busy1, to1, cnt1});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      expect_idle4("reset_idle", 3);
   endtask

   task automatic test_basic;
      pulse4(W'(5));
      follow4("basic_k5", 5, W'(0), 1'b0, -1);
      expect_idle4("basic_after", 3);
   endtask

   task automatic test_bounds;
      pulse4(W'(0));
      follow4("bound_k0", 1, W'(0), 1'b0, -1);
      expect_idle4("bound_k0_after", 2);
      pulse4(W'(127));
      follow4("bound_k127", 127, W'(0), 1'b0, -1);
      expect_idle4("bound_k127_after", 2);
   endtask

   task automatic test_random;
      int r, n;
      for (int i = 0; i < 6; i++) begin
         r = $urandom_range(0, 40);
         n = (r == 0) ? 1 : r;
         pulse4(W'(r));
         follow4("random_k", n, W'(0), 1'b1, -1);
         expect_idle4("random_after", 1 + $urandom_range(0, 3));
      end
   endtask

   task automatic test_back_to_back;
      int r, knew;
      r    = $urandom_range(1, 10);
      knew = (r == 3) ? 4 : r;
      k4   = W'(3);
      trig4 = 1'b1;
      @(negedge clk);
      follow4("held_first", 3, W'(knew), 1'b1, -1);
      expect_idle4("held_gap", 1);
      trig4 = 1'b0;
      follow4("held_second", knew, W'(0), 1'b0, -1);
      expect_idle4("held_after", 3);
   endtask

   task automatic test_abort;
      pulse4(W'(5));
      follow4("abort_run", 5, W'(0), 1'b0, 12);
      expect_idle4("abort_after", 40);
      abort4 = 1'b1;
      trig4  = 1'b1;
      k4     = W'(9);
      expect_idle4("abort_and_trigger", 5);
      abort4 = 1'b0;
      trig4  = 1'b0;
      expect_idle4("abort_release", 2);
   endtask

   task automatic test_async_reset;
      pulse4(W'(9));
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({en4, busy4, to4, cnt4} !== {1'b1, 1'b0, 1'b0, W'(0)}) begin
         n_fail++;
         $display("FAIL async_reset got %b required %b", {en4, busy4, to4, cnt4},
                  {1'b1, 1'b0, 1'b0, W'(0)});
      end
      @(negedge clk);
      rst = 1'b0;
      expect_idle4("post_reset", 60);
   endtask

   task automatic test_prescale1;
      logic [W+2:0] got, exp;
      int r, n;
      for (int i = 0; i < 5; i++) begin
         r = (i == 0) ? 1 : $urandom_range(0, 127);
         n = (r == 0) ? 1 : r;
         k1 = W'(r);
         trig1 = 1'b1;
         @(negedge clk);
         trig1 = 1'b0;
         for (int j = 0; j <= n + 1; j++) begin
            if (j <= n) exp = {1'b0, 1'b1, (j == n), (j < n) ? W'(n - j) : W'(0)};
            else        exp = {1'b1, 1'b0, 1'b0, W'(0)};
            got = {en1, busy1, to1, cnt1};
            n_checks++;
            if (got !== exp) begin
               n_fail++;
               $display("FAIL p1_single n=%0d j=%0d got %b required %b", n, j, got, exp);
            end
            @(negedge clk);
         end
      end
      // Held trigger with k=1: COUNT, DONE, IDLE repeating every 3 cycles.
      k1 = W'(1);
      trig1 = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 12; j++) begin
         exp = {(j % 3 == 2), (j % 3 != 2), (j % 3 == 1), (j % 3 == 0) ? W'(1) : W'(0)};
         got = {en1, busy1, to1, cnt1};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL p1_back_to_back j=%0d got %b required %b", j, got, exp);
         end
         @(negedge clk);
      end
      trig1 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bounds();
      test_random();
      test_back_to_back();
      test_abort();
      test_async_reset();
      test_prescale1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
